mmio_ctrl: RTL

MMIO_CTRL -- requirements
Module: mmio_ctrl

---
 rtl/mmio_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/mmio_ctrl.sv
// Memory-mapped I/O controller: decodes EX-stage addresses onto DMEM/IMEM/BIOS
// and the UART/counter registers, formats stores and aligns WB-stage load data.
module mmio_ctrl #(
  parameter int DMEM_AWIDTH = 14,
  parameter int IMEM_AWIDTH = 14,
  parameter int BIOS_AWIDTH = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            addr_i,
  input  logic [31:0]            wdata_i,
  input  logic [2:0]             funct3_i,
  input  logic                   mem_rd_i,
  input  logic                   mem_wr_i,
  input  logic                   pc_bios_i,
  output logic [DMEM_AWIDTH-1:0] dmem_addr_o,
  output logic [31:0]            dmem_wdata_o,
  output logic [3:0]             dmem_wbe_o,
  input  logic [31:0]            dmem_rdata_i,
  output logic [IMEM_AWIDTH-1:0] imem_addr_o,
  output logic [31:0]            imem_wdata_o,
  output logic [3:0]             imem_wbe_o,
  output logic [BIOS_AWIDTH-1:0] bios_addr_o,
  input  logic [31:0]            bios_rdata_i,
  output logic [7:0]             uart_tx_data_o,
  output logic                   uart_tx_valid_o,
  input  logic                   uart_tx_ready_i,
  input  logic [7:0]             uart_rx_data_i,
  input  logic                   uart_rx_valid_i,
  output logic                   uart_rx_ready_o,
  input  logic                   inst_retire_i,
  output logic [31:0]            rdata_o
);

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_DMEM,
    SRC_BIOS,
    SRC_IO
  } src_t;

  localparam logic [25:0] IO_STATUS = 26'd0;
  localparam logic [25:0] IO_RX     = 26'd1;
  localparam logic [25:0] IO_TX     = 26'd2;
  localparam logic [25:0] IO_CYCLE  = 26'd4;
  localparam logic [25:0] IO_RETIRE = 26'd5;
  localparam logic [25:0] IO_CLEAR  = 26'd6;

  logic [3:0]  region;
  logic [25:0] io_word;
  logic        is_dmem, is_imem, is_bios, is_io;
  logic        is_load, is_store;
  logic [3:0]  store_wbe;
  logic [31:0] store_wdata;
  logic        store_ok;
  logic        tx_wr, cnt_clr;
  logic [31:0] cycle_cnt, retired_cnt;
  logic [31:0] io_rdata;
  src_t        next_src, ld_src;
  logic [1:0]  ld_off;
  logic [2:0]  ld_funct3;
  logic [31:0] ld_io;
  logic [31:0] src_word;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign region  = addr_i[31:28];
  assign io_word = addr_i[27:2];

  // 4'b0011 hits both dmem and imem; loads from it come from dmem.
  assign is_dmem = (region[3:2] == 2'b00) && region[0];
  assign is_imem = (region[3:1] == 3'b001);
  assign is_bios = (region == 4'b0100);
  assign is_io   = (region == 4'b1000);

  assign is_store = mem_wr_i;
  assign is_load  = mem_rd_i && !mem_wr_i;

  assign dmem_addr_o = addr_i[DMEM_AWIDTH+1:2];
  assign imem_addr_o = addr_i[IMEM_AWIDTH+1:2];
  assign bios_addr_o = addr_i[BIOS_AWIDTH+1:2];

  // A misaligned or unknown-size store leaves store_wbe at zero, which also
  // suppresses the IO side effects through store_ok.
  always_comb begin
    store_wbe   = 4'b0000;
    store_wdata = wdata_i;
    case (funct3_i)
      3'b000: begin
        store_wbe   = 4'b0001 << addr_i[1:0];
        store_wdata = {4{wdata_i[7:0]}};
      end
      3'b001: begin
        store_wdata = {2{wdata_i[15:0]}};
        if (!addr_i[0]) store_wbe = 4'b0011 << {addr_i[1], 1'b0};
      end
      3'b010: begin
        if (addr_i[1:0] == 2'b00) store_wbe = 4'b1111;
      end
      default: store_wbe = 4'b0000;
    endcase
  end

  assign store_ok     = |store_wbe;
  assign dmem_wdata_o = store_wdata;
  assign imem_wdata_o = store_wdata;
  assign dmem_wbe_o   = (rst && is_store && is_dmem) ? store_wbe : 4'b0000;
  assign imem_wbe_o   = (rst && is_store && is_imem && pc_bios_i) ? store_wbe : 4'b0000;

  assign tx_wr           = is_store && is_io && (io_word == IO_TX) && store_ok;
  assign cnt_clr         = is_store && is_io && (io_word == IO_CLEAR) && store_ok;
  assign uart_rx_ready_o = rst && is_load && is_io && (io_word == IO_RX);

  always_comb begin
    io_rdata = 32'd0;
    case (io_word)
      IO_STATUS: io_rdata = {30'd0, uart_rx_valid_i, ~uart_tx_valid_o};
      IO_RX:     io_rdata = {24'd0, uart_rx_data_i};
      IO_CYCLE:  io_rdata = cycle_cnt;
      IO_RETIRE: io_rdata = retired_cnt;
      default:   io_rdata = 32'd0;
    endcase
  end

  always_comb begin
    next_src = SRC_NONE;
    if (is_load) begin
      if (is_dmem)      next_src = SRC_DMEM;
      else if (is_bios) next_src = SRC_BIOS;
      else if (is_io)   next_src = SRC_IO;
    end
  end

  // IO values are snapshotted in EX so the WB result matches the load's cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_src    <= SRC_NONE;
      ld_off    <= 2'b00;
      ld_funct3 <= 3'b000;
      ld_io     <= 32'd0;
    end else begin
      ld_src    <= next_src;
      ld_off    <= addr_i[1:0];
      ld_funct3 <= funct3_i;
      ld_io     <= io_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt   <= 32'd0;
      retired_cnt <= 32'd0;
    end else if (cnt_clr) begin
      cycle_cnt   <= 32'd0;
      retired_cnt <= 32'd0;
    end else begin
      cycle_cnt   <= cycle_cnt + 32'd1;
      retired_cnt <= retired_cnt + {31'd0, inst_retire_i};
    end
  end

  // A store that arrives while a byte is still pending is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      uart_tx_valid_o <= 1'b0;
      uart_tx_data_o  <= 8'd0;
    end else if (uart_tx_valid_o) begin
      if (uart_tx_ready_i) uart_tx_valid_o <= 1'b0;
    end else if (tx_wr) begin
      uart_tx_valid_o <= 1'b1;
      uart_tx_data_o  <= wdata_i[7:0];
    end
  end

  always_comb begin
    src_word = 32'd0;
    case (ld_src)
      SRC_DMEM: src_word = dmem_rdata_i;
      SRC_BIOS: src_word = bios_rdata_i;
      SRC_IO:   src_word = ld_io;
      default:  src_word = 32'd0;
    endcase
  end

  assign byte_sel = src_word[{ld_off, 3'b000} +: 8];
  assign half_sel = ld_off[1] ? src_word[31:16] : src_word[15:0];

  always_comb begin
    rdata_o = 32'd0;
    case (ld_funct3)
      3'b000:  rdata_o = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  rdata_o = {{16{half_sel[15]}}, half_sel};
      3'b010:  rdata_o = src_word;
      3'b100:  rdata_o = {24'd0, byte_sel};
      3'b101:  rdata_o = {16'd0, half_sel};
      default: rdata_o = 32'd0;
    endcase
  end

endmodule
